// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package instruction_fetch_unit_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_packet_t;

   localparam int unsigned FETCH_STEP = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_checker.sv
// Invariant checks for the fetch front-end: credit bounds, drop bound, legal responses, stable requests.
module instruction_fetch_unit_checker #(
   parameter int XLEN            = 32,
   parameter int FB_DEPTH        = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input logic                                 clk_i,
   input logic                                 rst_ni,
   input logic                                 mem_read_i,
   input logic                                 mem_gnt_i,
   input logic                                 mem_resp_i,
   input logic [XLEN-1:0]                      mem_address_i,
   input logic [$clog2(FB_DEPTH+1)-1:0]        count_i,
   input logic [$clog2(MAX_OUTSTANDING+1)-1:0] outst_i,
   input logic [$clog2(MAX_OUTSTANDING+1)-1:0] drop_i
);

   count_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      32'(count_i) <= 32'(FB_DEPTH));

   outst_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      32'(outst_i) <= 32'(MAX_OUTSTANDING));

   drop_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      drop_i <= outst_i);

   resp_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      mem_resp_i |-> (outst_i != '0));

   addr_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (mem_read_i && !mem_gnt_i) |=> $stable(mem_address_i));

endmodule

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Circular FIFO holding fetched {pc, instr} packets; any depth >= 1, synchronous flush.
module instruction_fetch_unit_fetch_buffer
   import instruction_fetch_unit_pkg::*;
#(
   parameter int WIDTH = $bits(fetch_packet_t),
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_s, do_pop_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return PW'(0);
      else                     return p + PW'(1);
   endfunction

   // Pointer and occupancy update; a flush overrides push and pop.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      do_pop_s  = pop_i && (count_q != CW'(0));
      do_push_s = push_i && ((count_q != CW'(DEPTH)) || do_pop_s);
      if (clear_i) begin
         head_d    = PW'(0);
         tail_d    = PW'(0);
         count_d   = CW'(0);
         do_pop_s  = 1'b0;
         do_push_s = 1'b0;
      end else begin
         if (do_push_s) tail_d = ptr_inc(tail_q);
         else           tail_d = tail_q;
         if (do_pop_s)  head_d = ptr_inc(head_q);
         else           head_d = head_q;
         count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

   // Pointer/occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= PW'(0);
         tail_q  <= PW'(0);
         count_q <= CW'(0);
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage; cleared on reset so the head reads as zero while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= WIDTH'(0);
      end else if (do_push_s) begin
         mem_q[tail_q] <= data_i;
      end
   end

   assign data_o  = mem_q[head_q];
   assign valid_o = (count_q != CW'(0));
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Pipelined, redirectable fetch front-end: several in-order reads in flight,
// responses buffered with their PC, stale responses dropped after a redirect.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter int              FB_DEPTH        = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = XLEN'(32'h0000_0060)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_branch_i,
   input  logic [XLEN-1:0] branch_pc_i,
   output logic            mem_read_o,
   output logic [XLEN-1:0] mem_address_o,
   input  logic            mem_gnt_i,
   input  logic            mem_resp_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            instr_vld_o,
   input  logic            instr_rdy_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o
);

   localparam int              OW   = $clog2(MAX_OUTSTANDING + 1);
   localparam int              CW   = $clog2(FB_DEPTH + 1);
   localparam logic [XLEN-1:0] STEP = XLEN'(FETCH_STEP);

   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target_s;
   logic [OW-1:0]     outst_q, outst_d, drop_q, drop_d;
   logic [CW-1:0]     count_s;
   logic              grant_s, resp_s, push_s, pop_s;
   logic [2*XLEN-1:0] head_s;

   assign target_s = {branch_pc_i[XLEN-1:2], 2'b00};

   // Every in-flight read owns a buffer slot, so a granted read can always be stored.
   assign mem_read_o    = rst && !load_branch_i
                          && (outst_q < OW'(MAX_OUTSTANDING))
                          && ((32'(count_s) + 32'(outst_q)) < 32'(FB_DEPTH));
   assign mem_address_o = fetch_pc_q;
   assign grant_s       = mem_read_o && mem_gnt_i;
   assign resp_s        = mem_resp_i && (outst_q != OW'(0));
   assign pop_s         = instr_vld_o && instr_rdy_i;

   // Next-state for PCs and the outstanding/drop counters; redirect wins over everything.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      drop_d     = drop_q;
      push_s     = 1'b0;
      outst_d    = outst_q + OW'(grant_s) - OW'(resp_s);
      if (load_branch_i) begin
         fetch_pc_d = target_s;
         resp_pc_d  = target_s;
         drop_d     = outst_d;
      end else begin
         if (grant_s) fetch_pc_d = fetch_pc_q + STEP;
         else         fetch_pc_d = fetch_pc_q;
         if (resp_s && (drop_q != OW'(0))) begin
            drop_d = drop_q - OW'(1);
         end else if (resp_s) begin
            push_s    = 1'b1;
            resp_pc_d = resp_pc_q + STEP;
         end else begin
            push_s = 1'b0;
         end
      end
   end

   // Fetch-side state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= OW'(0);
         drop_q     <= OW'(0);
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   instruction_fetch_unit_fetch_buffer #(
      .WIDTH (2 * XLEN),
      .DEPTH (FB_DEPTH)
   ) u_fetch_buffer (
      .clk     (clk),
      .rst_n   (rst),
      .clear_i (load_branch_i),
      .push_i  (push_s),
      .data_i  ({resp_pc_q, mem_rdata_i}),
      .pop_i   (pop_s),
      .data_o  (head_s),
      .valid_o (instr_vld_o),
      .count_o (count_s)
   );

   assign instr_pc_o = head_s[2*XLEN-1:XLEN];
   assign instr_o    = head_s[XLEN-1:0];

   instruction_fetch_unit_checker #(
      .XLEN            (XLEN),
      .FB_DEPTH        (FB_DEPTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_checker (
      .clk_i         (clk),
      .rst_ni        (rst),
      .mem_read_i    (mem_read_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_resp_i    (mem_resp_i),
      .mem_address_i (mem_address_o),
      .count_i       (count_s),
      .outst_i       (outst_q),
      .drop_i        (drop_q)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: an in-order memory model answers grants,
// and expected {pc, word} packets are queued per grant and retired as the decoder pops them.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_branch_i = 1'b0;
   logic [31:0] branch_pc_i = 32'h0;
   logic        mem_read_o;
   logic [31:0] mem_address_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_resp_i = 1'b0;
   logic [31:0] mem_rdata_i = 32'h0;
   logic        instr_vld_o;
   logic        instr_rdy_i = 1'b0;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;

   always #5 clk = ~clk;

   instruction_fetch_unit #(
      .XLEN(32), .FB_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0060)
   ) dut (
      .clk(clk), .rst(rst), .load_branch_i(load_branch_i), .branch_pc_i(branch_pc_i),
      .mem_read_o(mem_read_o), .mem_address_o(mem_address_o), .mem_gnt_i(mem_gnt_i),
      .mem_resp_i(mem_resp_i), .mem_rdata_i(mem_rdata_i), .instr_vld_o(instr_vld_o),
      .instr_rdy_i(instr_rdy_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_grant = 0;
   logic        gnt_en  = 1'b0;
   logic        resp_en = 1'b0;
   logic [31:0] exp_pc  = 32'h60;
   logic [31:0] pend_q[$];
   logic [63:0] exp_q[$];
   logic        s_read, s_vld, s_grant;
   logic [31:0] s_addr, s_pc, s_instr;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
   endfunction

   // One clock cycle: drive memory, sample away from the edge, score pops, then update the model.
   task automatic tick();
      logic [63:0] e;
      mem_gnt_i = gnt_en;
      if (resp_en && pend_q.size() != 0) begin
         mem_resp_i  = 1'b1;
         mem_rdata_i = word(pend_q[0]);
      end else begin
         mem_resp_i  = 1'b0;
         mem_rdata_i = 32'h0;
      end
      #1;
      s_read  = mem_read_o;
      s_addr  = mem_address_o;
      s_vld   = instr_vld_o;
      s_pc    = instr_pc_o;
      s_instr = instr_o;
      s_grant = s_read && mem_gnt_i;
      if (s_grant) begin
         n_tests++;
         if (s_addr !== exp_pc) begin
            n_fail++;
            $display("FAIL grant_addr: got %h expected %h", s_addr, exp_pc);
         end
      end
      if (s_vld && instr_rdy_i && !load_branch_i) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got pc %h instr %h expected nothing", s_pc, s_instr);
         end else begin
            e = exp_q.pop_front();
            if ({s_pc, s_instr} !== e) begin
               n_fail++;
               $display("FAIL output: got pc %h instr %h expected pc %h instr %h",
                        s_pc, s_instr, e[63:32], e[31:0]);
            end
         end
      end
      @(posedge clk);
      if (mem_resp_i) void'(pend_q.pop_front());
      if (s_grant) begin
         pend_q.push_back(s_addr);
         exp_q.push_back({exp_pc, word(exp_pc)});
         exp_pc = exp_pc + 32'd4;
         n_grant++;
      end
      if (load_branch_i) begin
         exp_q.delete();
         exp_pc = {branch_pc_i[31:2], 2'b00};
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      load_branch_i = 1'b0;
      mem_gnt_i = 1'b0;
      mem_resp_i = 1'b0;
      gnt_en = 1'b0;
      pend_q.delete();
      exp_q.delete();
      exp_pc = 32'h60;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic drain();
      int k = 0;
      gnt_en = 1'b0; resp_en = 1'b1; instr_rdy_i = 1'b1; load_branch_i = 1'b0;
      while ((exp_q.size() != 0 || pend_q.size() != 0) && k < 40) begin
         tick();
         k++;
      end
      n_tests++;
      if (exp_q.size() != 0 || pend_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d/%0d left expected 0/0", exp_q.size(), pend_q.size());
      end
      tick();
      n_tests++;
      if (s_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_idle_vld: got %b expected 0", s_vld);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk);
      #1;
      n_tests += 5;
      if (mem_read_o !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %b expected 0", mem_read_o); end
      if (instr_vld_o !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b expected 0", instr_vld_o); end
      if (mem_address_o !== 32'h60) begin n_fail++; $display("FAIL rst_addr: got %h expected 00000060", mem_address_o); end
      if (instr_o !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h expected 0", instr_o); end
      if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 0", instr_pc_o); end
      rst = 1'b1;
   endtask

   task automatic test_stream();
      int first_g = -1;
      int first_v = -1;
      gnt_en = 1'b1; resp_en = 1'b1; instr_rdy_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (s_grant && first_g < 0) first_g = i;
         if (s_vld && first_v < 0) first_v = i;
      end
      n_tests++;
      if (first_g < 0 || first_v - first_g != 2) begin
         n_fail++;
         $display("FAIL stream_latency: got %0d expected 2", first_v - first_g);
      end
      drain();
   endtask

   task automatic test_full();
      int g0;
      instr_rdy_i = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
      g0 = n_grant;
      repeat (12) tick();
      n_tests += 3;
      if (n_grant - g0 != 4) begin n_fail++; $display("FAIL full_grants: got %0d expected 4", n_grant - g0); end
      if (s_read !== 1'b0) begin n_fail++; $display("FAIL full_read: got %b expected 0", s_read); end
      if (s_vld !== 1'b1) begin n_fail++; $display("FAIL full_vld: got %b expected 1", s_vld); end
      instr_rdy_i = 1'b1;
      tick();
      instr_rdy_i = 1'b0;
      g0 = n_grant;
      repeat (8) tick();
      n_tests++;
      if (n_grant - g0 != 1) begin n_fail++; $display("FAIL full_refill: got %0d expected 1", n_grant - g0); end
      drain();
   endtask

   task automatic test_redirect();
      int g0;
      do_reset();
      instr_rdy_i = 1'b1; resp_en = 1'b0; gnt_en = 1'b1;
      g0 = n_grant;
      repeat (4) tick();
      n_tests++;
      if (n_grant - g0 != 2) begin n_fail++; $display("FAIL redir_outst: got %0d expected 2", n_grant - g0); end
      gnt_en = 1'b1;
      load_branch_i = 1'b1; branch_pc_i = 32'h300;
      tick();
      n_tests++;
      if (s_read !== 1'b0) begin n_fail++; $display("FAIL redir_noissue: got %b expected 0", s_read); end
      branch_pc_i = 32'h103;
      tick();
      load_branch_i = 1'b0; resp_en = 1'b1;
      repeat (8) tick();
      drain();
   endtask

   task automatic test_redirect_collide();
      int g0;
      int k = 0;
      do_reset();
      instr_rdy_i = 1'b0; resp_en = 1'b1; gnt_en = 1'b1;
      g0 = n_grant;
      while (n_grant - g0 < 3 && k < 10) begin tick(); k++; end
      gnt_en = 1'b0;
      load_branch_i = 1'b1; branch_pc_i = 32'h200; instr_rdy_i = 1'b1;
      tick();
      n_tests++;
      if (s_vld !== 1'b1) begin n_fail++; $display("FAIL collide_pre_vld: got %b expected 1", s_vld); end
      load_branch_i = 1'b0;
      tick();
      n_tests++;
      if (s_vld !== 1'b0) begin n_fail++; $display("FAIL collide_vld: got %b expected 0", s_vld); end
      gnt_en = 1'b1;
      repeat (8) tick();
      drain();
   endtask

   task automatic test_stall();
      logic [31:0] a;
      instr_rdy_i = 1'b1; resp_en = 1'b1; gnt_en = 1'b0;
      a = exp_pc;
      repeat (3) begin
         tick();
         n_tests++;
         if (s_read !== 1'b1 || s_addr !== a) begin
            n_fail++;
            $display("FAIL stall_hold: got read %b addr %h expected read 1 addr %h", s_read, s_addr, a);
         end
      end
      gnt_en = 1'b1;
      tick();
      gnt_en = 1'b0;
      tick();
      n_tests++;
      if (s_addr !== a + 32'd4) begin n_fail++; $display("FAIL stall_advance: got %h expected %h", s_addr, a + 32'd4); end
      drain();
   endtask

   task automatic test_reset_mid();
      int g0;
      int k = 0;
      do_reset();
      instr_rdy_i = 1'b0; resp_en = 1'b1; gnt_en = 1'b1;
      g0 = n_grant;
      while (n_grant - g0 < 2 && k < 10) begin tick(); k++; end
      gnt_en = 1'b0;
      repeat (2) tick();
      resp_en = 1'b0; gnt_en = 1'b1;
      while (n_grant - g0 < 4 && k < 20) begin tick(); k++; end
      gnt_en = 1'b0;
      #1 rst = 1'b0;
      #1;
      n_tests += 4;
      if (mem_read_o !== 1'b0) begin n_fail++; $display("FAIL midrst_read: got %b expected 0", mem_read_o); end
      if (instr_vld_o !== 1'b0) begin n_fail++; $display("FAIL midrst_vld: got %b expected 0", instr_vld_o); end
      if (mem_address_o !== 32'h60) begin n_fail++; $display("FAIL midrst_addr: got %h expected 00000060", mem_address_o); end
      if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL midrst_pc: got %h expected 0", instr_pc_o); end
      pend_q.delete();
      exp_q.delete();
      exp_pc = 32'h60;
      mem_resp_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      gnt_en = 1'b1; resp_en = 1'b1; instr_rdy_i = 1'b1;
      repeat (6) tick();
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect();
      test_redirect_collide();
      test_stall();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
